// File: rtl/sha3_pkg.sv
// sha3_pkg: shared SHA3-256 sponge constants, FSM state type and byte-mask helper.
// SHA3_KECCAK_LEGACY_EN selects Keccak-256 domain padding (0x01) instead of SHA3 (0x06).
package sha3_pkg;
    localparam int STATE_W      = 1600;
    localparam int LANE_W       = 64;
    localparam int RATE_LANES   = 17;
    localparam int RATE_BYTES   = RATE_LANES * LANE_W / 8;
    localparam int DIGEST_BITS  = 256;
    localparam int PERM_LATENCY = 8;
    localparam int CNT_W        = $clog2(RATE_LANES);
    localparam int PC_W         = $clog2(PERM_LATENCY + 1);
    localparam logic [7:0] PAD_END = 8'h80;
`ifdef SHA3_KECCAK_LEGACY_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif
    localparam logic [STATE_W-1:0] PAD_BLOCK =
        (STATE_W'(PAD_END) << (8 * (RATE_BYTES - 1))) | STATE_W'(DOMAIN_BYTE);

    typedef enum logic [1:0] {ABSORB, PERM, PADBLK, OUT} state_e;

    // Keeps the first k bytes of a lane; k >= 8 keeps the whole lane.
    function automatic logic [LANE_W-1:0] byte_mask(input logic [3:0] k);
        return k[3] ? {LANE_W{1'b1}} : ~({LANE_W{1'b1}} << {k[2:0], 3'b000});
    endfunction
endpackage

// File: rtl/sha3_sponge_ctrl_if.sv
// sha3_sponge_ctrl_if: message input, digest output and permutation port bundle.
interface sha3_sponge_ctrl_if;
    import sha3_pkg::*;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANE_W-1:0]      in_data;
    logic                   in_last;
    logic [3:0]             in_bytes;
    logic [STATE_W-1:0]     perm_in;
    logic [STATE_W-1:0]     perm_out;
    logic                   digest_valid;
    logic                   digest_ready;
    logic [DIGEST_BITS-1:0] digest;
    logic                   busy;

    modport master (
        output in_valid, in_data, in_last, in_bytes, digest_ready, perm_out,
        input  in_ready, digest_valid, digest, perm_in, busy
    );
    modport slave (
        input  in_valid, in_data, in_last, in_bytes, digest_ready, perm_out,
        output in_ready, digest_valid, digest, perm_in, busy
    );
endinterface

// File: rtl/sha3_pad_mask.sv
// sha3_pad_mask: builds the state XOR vector for one accepted word (masked data plus pad bytes).
module sha3_pad_mask import sha3_pkg::*; (
    input  logic [CNT_W-1:0]   cnt_i,
    input  logic [3:0]         in_bytes_i,
    input  logic               in_last_i,
    input  logic [LANE_W-1:0]  in_data_i,
    output logic [STATE_W-1:0] xor_o,
    output logic               spill_o
);
    logic [LANE_W-1:0] data_m;
    logic [7:0]        pos;
    logic              fits;

    assign data_m = in_data_i & (in_last_i ? byte_mask(in_bytes_i) : {LANE_W{1'b1}});
    // Byte offset of the domain byte; a full last word pushes it into the next lane.
    assign pos = {cnt_i, 3'b000} + (in_bytes_i[3] ? 8'd8 : {5'd0, in_bytes_i[2:0]});
    assign fits = pos < 8'(RATE_BYTES);
    assign xor_o = (STATE_W'(data_m) << {cnt_i, 6'd0})
                 ^ ((in_last_i && fits)
                    ? (STATE_W'(DOMAIN_BYTE) << {pos, 3'b000})
                      ^ (STATE_W'(PAD_END) << (8 * (RATE_BYTES - 1)))
                    : '0);
    assign spill_o = in_last_i && !fits;
endmodule

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: SHA3-256 sponge driver for an 8-stage Keccak-f[1600] pipeline.
// Define SHA3_KECCAK_LEGACY_EN for original Keccak-256 padding.
module sha3_sponge_ctrl import sha3_pkg::*; (
    input logic               clk,
    input logic               rst,
    sha3_sponge_ctrl_if.slave bus
);
    state_e             state_q;
    logic [STATE_W-1:0] st_q;
    logic [STATE_W-1:0] xor_vec;
    logic [CNT_W-1:0]   cnt_q;
    logic [PC_W-1:0]    pc_q;
    logic               final_q;
    logic               pad_pend_q;
    logic               in_ready_q;
    logic               digest_valid_q;
    logic               busy_q;
    logic               spill;

    sha3_pad_mask u_pad (
        .cnt_i      (cnt_q),
        .in_bytes_i (bus.in_bytes),
        .in_last_i  (bus.in_last),
        .in_data_i  (bus.in_data),
        .xor_o      (xor_vec),
        .spill_o    (spill)
    );

    assign bus.perm_in      = st_q;
    assign bus.digest       = st_q[DIGEST_BITS-1:0];
    assign bus.in_ready     = in_ready_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.busy         = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ABSORB;
            st_q           <= '0;
            cnt_q          <= '0;
            pc_q           <= '0;
            final_q        <= 1'b0;
            pad_pend_q     <= 1'b0;
            in_ready_q     <= 1'b1;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ABSORB: if (bus.in_valid && in_ready_q) begin
                    st_q <= st_q ^ xor_vec;
                    if (bus.in_last || cnt_q == CNT_W'(RATE_LANES - 1)) begin
                        cnt_q      <= '0;
                        pc_q       <= '0;
                        final_q    <= bus.in_last && !spill;
                        pad_pend_q <= spill;
                        state_q    <= PERM;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PERM: if (pc_q == PC_W'(PERM_LATENCY)) begin
                    st_q <= bus.perm_out;
                    pc_q <= '0;
                    if (final_q) begin
                        state_q        <= OUT;
                        digest_valid_q <= 1'b1;
                    end else if (pad_pend_q) begin
                        state_q <= PADBLK;
                    end else begin
                        state_q    <= ABSORB;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end else begin
                    pc_q <= pc_q + PC_W'(1);
                end
                PADBLK: begin
                    st_q       <= st_q ^ PAD_BLOCK;
                    pad_pend_q <= 1'b0;
                    final_q    <= 1'b1;
                    state_q    <= PERM;
                end
                OUT: if (bus.digest_ready) begin
                    st_q           <= '0;
                    cnt_q          <= '0;
                    final_q        <= 1'b0;
                    state_q        <= ABSORB;
                    in_ready_q     <= 1'b1;
                    digest_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
                default: state_q <= ABSORB;
            endcase
        end
    end
endmodule
